// File: rtl/bomberman_pkg.sv
// Shared types and constants for the bomberman video pipeline.
// Frame-index helpers map player direction and walk phase onto the sprite ROM layout.
package bomberman_pkg;

  typedef enum logic [1:0] {DIR_DOWN, DIR_UP, DIR_LEFT, DIR_RIGHT} dir_e;

  typedef enum logic [2:0] {IDLE, STEP_A, MID_A, STEP_B, MID_B} anim_state_e;

  localparam int unsigned FRAME_BASE_DOWN = 0;
  localparam int unsigned FRAME_BASE_SIDE = 3;
  localparam int unsigned FRAME_BASE_UP   = 6;

  function automatic int unsigned frame_base(dir_e d);
    case (d)
      DIR_DOWN: return FRAME_BASE_DOWN;
      DIR_UP:   return FRAME_BASE_UP;
      default:  return FRAME_BASE_SIDE;
    endcase
  endfunction

  // Offset within a direction's three frames: 0 stand, 1 step A, 2 step B.
  function automatic int unsigned anim_phase(anim_state_e s);
    case (s)
      STEP_A:  return 1;
      STEP_B:  return 2;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/player_anim_fsm.sv
// Walk-animation divider and state machine; produces the sprite frame index.
// Direction and moving are only sampled on frame_start so a frame never tears.
module player_anim_fsm
  import bomberman_pkg::*;
#(
  parameter int unsigned ANIM_DIV = 8,
  parameter int unsigned FRAME_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [1:0]         dir,
  input  logic               moving,
  output logic [FRAME_W-1:0] frame
);

  localparam int unsigned DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  anim_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  dir_e             dir_q, dir_d;
  logic             moving_q, moving_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      dir_q    <= DIR_DOWN;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    dir_d    = dir_q;
    moving_d = moving_q;
    if (frame_start) begin
      dir_d    = dir_e'(dir);
      moving_d = moving;
      // Stop beats a step; a fresh start or a turn restarts the walk cycle.
      if (!moving) begin
        state_d = IDLE;
        div_d   = '0;
      end else if (!moving_q || (dir_e'(dir) != dir_q)) begin
        state_d = STEP_A;
        div_d   = '0;
      end else if (div_q == DIV_W'(ANIM_DIV - 1)) begin
        div_d = '0;
        case (state_q)
          STEP_A:  state_d = MID_A;
          MID_A:   state_d = STEP_B;
          STEP_B:  state_d = MID_B;
          MID_B:   state_d = STEP_A;
          default: state_d = state_q;
        endcase
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  assign frame = FRAME_W'(frame_base(dir_q) + anim_phase(state_q));

endmodule

// File: rtl/player_sprite_fetch.sv
// Player sprite fetch: hit test and mirrored row-major ROM address from the scan position,
// with a 2-stage pipeline so hit lines up with the ROM data returned by player_sprites.
module player_sprite_fetch
  import bomberman_pkg::*;
#(
  parameter int unsigned SPRITE_W   = 32,
  parameter int unsigned SPRITE_H   = 48,
  parameter int unsigned NUM_FRAMES = 9,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned ANIM_DIV   = 8,
  localparam int unsigned ADDR_W    = $clog2(SPRITE_W * SPRITE_H),
  localparam int unsigned FRAME_W   = $clog2(NUM_FRAMES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [1:0]         dir,
  input  logic               moving,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               pix_valid,
  output logic [ADDR_W-1:0]  addr,
  output logic [FRAME_W-1:0] frame,
  output logic               hit
);

  localparam int unsigned COL_W = $clog2(SPRITE_W);
  localparam int unsigned ROW_W = $clog2(SPRITE_H);

  logic [COORD_W-1:0] px_q, py_q;
  logic               left_q;
  logic [FRAME_W-1:0] fsm_frame;
  logic [COORD_W:0]   dx, dy;
  logic               in_box;
  logic [COL_W-1:0]   col;
  logic [ADDR_W-1:0]  addr_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [FRAME_W-1:0] frame_q;
  logic               hit1_q, hit_q;

  player_anim_fsm #(
    .ANIM_DIV (ANIM_DIV),
    .FRAME_W  (FRAME_W)
  ) u_anim (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .dir         (dir),
    .moving      (moving),
    .frame       (fsm_frame)
  );

  // Position and mirroring are latched with the animation so the box moves only between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      px_q   <= '0;
      py_q   <= '0;
      left_q <= 1'b0;
    end else if (frame_start) begin
      px_q   <= player_x;
      py_q   <= player_y;
      left_q <= (dir_e'(dir) == DIR_LEFT);
    end
  end

  always_comb begin
    dx     = {1'b0, pix_x} - {1'b0, px_q};
    dy     = {1'b0, pix_y} - {1'b0, py_q};
    // Top bit set means the scan is left of / above the sprite origin.
    in_box = pix_valid
           & ~dx[COORD_W] & (dx[COORD_W-1:0] < COORD_W'(SPRITE_W))
           & ~dy[COORD_W] & (dy[COORD_W-1:0] < COORD_W'(SPRITE_H));
    col    = left_q ? (COL_W'(SPRITE_W - 1) - dx[COL_W-1:0]) : dx[COL_W-1:0];
    addr_d = '0;
    if (in_box) begin
      addr_d = ADDR_W'(dy[ROW_W-1:0]) * ADDR_W'(SPRITE_W) + ADDR_W'(col);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      frame_q <= '0;
      hit1_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      frame_q <= fsm_frame;
      hit1_q  <= in_box;
      hit_q   <= hit1_q;
    end
  end

  assign addr  = addr_q;
  assign frame = frame_q;
  assign hit   = hit_q;

endmodule

// File: tb/tb_player_sprite_fetch.sv
// Self-checking bench for player_sprite_fetch with ANIM_DIV=2: directed tables plus
// randomized traffic against a walk-count reference model.
module tb_player_sprite_fetch;

  localparam int DIV = 2;

  logic        clk, rst, frame_start, moving, pix_valid;
  logic [1:0]  dir;
  logic [9:0]  player_x, player_y, pix_x, pix_y;
  logic [10:0] addr;
  logic [3:0]  frame;
  logic        hit;

  int total = 0;
  int bad   = 0;

  player_sprite_fetch #(
    .SPRITE_W   (32),
    .SPRITE_H   (48),
    .NUM_FRAMES (9),
    .COORD_W    (10),
    .ANIM_DIV   (DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .dir         (dir),
    .moving      (moving),
    .player_x    (player_x),
    .player_y    (player_y),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_valid   (pix_valid),
    .addr        (addr),
    .frame       (frame),
    .hit         (hit)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic fs_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  // Reference model: walk phase derived from frame_starts since the walk began.
  int m_moving, m_dir, m_walk, m_px, m_py;

  function automatic int model_frame();
    int base, ph;
    int pat[4];
    pat = '{1, 0, 2, 0};
    base = (m_dir == 0) ? 0 : (m_dir == 1) ? 6 : 3;
    ph = m_moving ? pat[(m_walk / DIV) % 4] : 0;
    return base + ph;
  endfunction

  function automatic void model_addr(input int x, input int y, input int v,
                                     output int a, output int h);
    int dxi, dyi, c;
    dxi = x - m_px;
    dyi = y - m_py;
    h = (v != 0) && dxi >= 0 && dxi < 32 && dyi >= 0 && dyi < 48;
    c = (m_dir == 2) ? 31 - dxi : dxi;
    a = h ? dyi * 32 + c : 0;
  endfunction

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  typedef struct {
    int px, py, v, exp_addr, exp_hit;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int   walk_seq[9];
    int   e_addr, e_hit, prev_hit, snap, nm, nd;

    vecs[0] = '{100,  50, 1,   31, 1};
    vecs[1] = '{131,  97, 1, 1504, 1};
    vecs[2] = '{132,  60, 1,    0, 0};
    vecs[3] = '{ 99,  60, 1,    0, 0};
    vecs[4] = '{110,  60, 0,    0, 0};
    vecs[5] = '{100,  97, 1, 1535, 1};
    vecs[6] = '{131,  50, 1,    0, 1};
    vecs[7] = '{100,  98, 1,    0, 0};
    walk_seq = '{1, 1, 0, 0, 2, 2, 0, 0, 1};

    rst = 1; frame_start = 0; dir = 0; moving = 0;
    player_x = 100; player_y = 50; pix_x = 0; pix_y = 0; pix_valid = 0;
    tick(); tick();
    check("reset_addr", int'(addr), 0);
    check("reset_frame", int'(frame), 0);
    check("reset_hit", int'(hit), 0);
    rst = 0;

    // Idle for five frames.
    for (int k = 0; k < 5; k++) begin
      fs_pulse();
      check("idle_frame", int'(frame), 0);
      check("idle_hit", int'(hit), 0);
    end

    // Walk down.
    dir = 2'd0; moving = 1;
    for (int k = 0; k < 9; k++) begin
      fs_pulse();
      check($sformatf("walk_down_%0d", k), int'(frame), walk_seq[k]);
    end

    // Direction change between frame_starts takes effect only at the next one.
    dir = 2'd1;
    tick(); tick(); tick();
    check("dir_pending", int'(frame), 1);
    fs_pulse();
    check("dir_up_stepa", int'(frame), 7);
    for (int k = 0; k < 4; k++) fs_pulse();
    check("up_stepb", int'(frame), 8);

    pix_x = 110; pix_y = 60; pix_valid = 1;
    tick(); tick();
    check("pre_rst_hit", int'(hit), 1);
    rst = 1;
    tick();
    check("rst_frame", int'(frame), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_hit0", int'(hit), 0);
    rst = 0;
    tick();
    check("rst_hit1", int'(hit), 0);
    check("rst_frame_idle", int'(frame), 0);
    pix_valid = 0;
    fs_pulse();
    check("restart_stepa", int'(frame), 7);

    // Left-facing, standing: box tests from the table.
    dir = 2'd2; moving = 0;
    fs_pulse();
    check("left_frame", int'(frame), 3);
    foreach (vecs[i]) begin
      pix_x = 10'(vecs[i].px); pix_y = 10'(vecs[i].py); pix_valid = vecs[i].v[0];
      tick();
      check($sformatf("vec%0d_addr", i), int'(addr), vecs[i].exp_addr);
      tick();
      check($sformatf("vec%0d_hit", i), int'(hit), vecs[i].exp_hit);
    end
    pix_valid = 0;

    // Randomized traffic from a clean reset.
    rst = 1; tick(); rst = 0;
    m_moving = 0; m_dir = 0; m_walk = 0; m_px = 0; m_py = 0;
    prev_hit = 0;
    for (int i = 0; i < 1500; i++) begin
      frame_start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) dir = 2'($urandom_range(0, 3));
      moving = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) begin
        player_x = 10'($urandom_range(0, 990));
        player_y = 10'($urandom_range(0, 970));
      end
      pix_x = 10'(clamp(m_px + int'($urandom_range(0, 40)) - 4));
      pix_y = 10'(clamp(m_py + int'($urandom_range(0, 56)) - 4));
      pix_valid = ($urandom_range(0, 7) != 0);
      model_addr(int'(pix_x), int'(pix_y), int'(pix_valid), e_addr, e_hit);
      snap = model_frame();
      if (frame_start) begin
        nm = int'(moving);
        nd = int'(dir);
        if (nm != 0) begin
          if (m_moving == 0 || nd != m_dir) m_walk = 0;
          else m_walk++;
        end
        m_moving = nm;
        m_dir = nd;
        m_px = int'(player_x);
        m_py = int'(player_y);
      end
      tick();
      check("rnd_addr", int'(addr), e_addr);
      check("rnd_frame", int'(frame), snap);
      if (i > 0) check("rnd_hit", int'(hit), prev_hit);
      prev_hit = e_hit;
    end
    frame_start = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
